scratch_stack_ram: RTL and testbench

//  Parametrised scratch RAM with a built-in hardware stack pointer for the MCU datapath.
//  - Keeps direct-address read/write for scratch variables.
//  - Adds PUSH/POP stack operations, SP load, occupancy tracking, full/empty flags and sticky overflow/underflow errors.
//  - Sits between the control unit and the register file; replaces the external SP register + address mux.

---
 rtl/scratch_stack_ram_if.sv | 33 +++
 rtl/scratch_stack_ram.sv | 111 +++++++++++
 tb/tb_scratch_stack_ram.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/scratch_stack_ram_if.sv
// Bus between the control unit and the scratch/stack RAM.
interface scratch_stack_ram_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] SCR_ADDR;
    logic [DATA_W-1:0] SCR_DIN;
    logic              SCR_WE;
    logic              PUSH;
    logic              POP;
    logic              SP_LD;
    logic [ADDR_W-1:0] SP_DIN;
    logic              ERR_CLR;
    logic [DATA_W-1:0] DATA_OUT;
    logic [ADDR_W-1:0] SP_OUT;
    logic [ADDR_W:0]   COUNT;
    logic              FULL;
    logic              EMPTY;
    logic              OVF;
    logic              UNF;

    // Control unit side
    modport master (
        output SCR_ADDR, SCR_DIN, SCR_WE, PUSH, POP, SP_LD, SP_DIN, ERR_CLR,
        input  DATA_OUT, SP_OUT, COUNT, FULL, EMPTY, OVF, UNF
    );

    // RAM side
    modport slave (
        input  SCR_ADDR, SCR_DIN, SCR_WE, PUSH, POP, SP_LD, SP_DIN, ERR_CLR,
        output DATA_OUT, SP_OUT, COUNT, FULL, EMPTY, OVF, UNF
    );
endinterface

// File: rtl/scratch_stack_ram.sv
// Scratch RAM with a downward-growing hardware stack, occupancy tracking
// and sticky overflow/underflow flags. Read data is combinational.
module scratch_stack_ram #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned SP_RST = 0
) (
    input  logic               CLK,
    input  logic               RST_N,
    scratch_stack_ram_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] sp_q,   sp_nxt;
    logic [CNT_W-1:0]  cnt_q,  cnt_nxt;
    logic              full_q, full_nxt;
    logic              empty_q, empty_nxt;
    logic              ovf_q,  ovf_nxt;
    logic              unf_q,  unf_nxt;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Next-state decode: SP load beats stack ops, stack ops beat direct write
    always_comb begin
        sp_nxt  = sp_q;
        cnt_nxt = cnt_q;
        ovf_nxt = ovf_q & ~bus.ERR_CLR;
        unf_nxt = unf_q & ~bus.ERR_CLR;
        wr_en   = 1'b0;
        wr_addr = bus.SCR_ADDR;

        if (bus.SP_LD) begin
            sp_nxt  = bus.SP_DIN;
            cnt_nxt = '0;
        end else if (bus.PUSH && bus.POP) begin
            // Replace top of stack in place
            if (empty_q) begin
                unf_nxt = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = sp_q;
            end
        end else if (bus.PUSH) begin
            if (full_q) begin
                ovf_nxt = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = sp_q - ADDR_W'(1);
                sp_nxt  = sp_q - ADDR_W'(1);
                cnt_nxt = cnt_q + CNT_W'(1);
            end
        end else if (bus.POP) begin
            if (empty_q) begin
                unf_nxt = 1'b1;
            end else begin
                sp_nxt  = sp_q + ADDR_W'(1);
                cnt_nxt = cnt_q - CNT_W'(1);
            end
        end else if (bus.SCR_WE) begin
            wr_en   = 1'b1;
            wr_addr = bus.SCR_ADDR;
        end

        full_nxt  = (cnt_nxt == CNT_W'(DEPTH));
        empty_nxt = (cnt_nxt == '0);
    end

    // Stack pointer, occupancy and flag registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp_q    <= ADDR_W'(SP_RST);
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_nxt;
            cnt_q   <= cnt_nxt;
            full_q  <= full_nxt;
            empty_q <= empty_nxt;
            ovf_q   <= ovf_nxt;
            unf_q   <= unf_nxt;
        end
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.SCR_DIN;
        end
    end

    // A pop reads the current top; otherwise the direct address
    always_comb begin
        rd_addr = bus.POP ? sp_q : bus.SCR_ADDR;
    end

    assign bus.DATA_OUT = mem[rd_addr];
    assign bus.SP_OUT   = sp_q;
    assign bus.COUNT    = cnt_q;
    assign bus.FULL     = full_q;
    assign bus.EMPTY    = empty_q;
    assign bus.OVF      = ovf_q;
    assign bus.UNF      = unf_q;
endmodule

// File: tb/tb_scratch_stack_ram.sv
// Directed bench for scratch_stack_ram: vector table plus hand sequences.
module tb_scratch_stack_ram;
    logic clk;
    logic rst_n;

    scratch_stack_ram_if #(.DATA_W(10), .ADDR_W(8)) bus ();

    scratch_stack_ram #(.DATA_W(10), .ADDR_W(8), .SP_RST(0)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       push;
        logic       pop;
        logic       we;
        logic       ld;
        logic       clr;
        logic [7:0] addr;
        logic [9:0] din;
        logic [7:0] spd;
        logic       cd;
        logic [9:0] dout;
        logic [7:0] sp;
        logic [8:0] cnt;
        logic       ovf;
        logic       unf;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t v(input logic push, pop, we, ld, clr,
                               input logic [7:0] addr, input logic [9:0] din,
                               input logic [7:0] spd, input logic cd,
                               input logic [9:0] dout, input logic [7:0] sp,
                               input logic [8:0] cnt, input logic ovf, unf);
        vec_t r;
        r.push = push; r.pop = pop; r.we = we; r.ld = ld; r.clr = clr;
        r.addr = addr; r.din = din; r.spd = spd; r.cd = cd; r.dout = dout;
        r.sp = sp; r.cnt = cnt; r.ovf = ovf; r.unf = unf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.PUSH = 1'b0; bus.POP = 1'b0; bus.SCR_WE = 1'b0; bus.SP_LD = 1'b0;
        bus.ERR_CLR = 1'b0; bus.SCR_ADDR = 8'h00; bus.SCR_DIN = 10'h000;
        bus.SP_DIN = 8'h00;
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] sp, input logic [8:0] cnt,
                            input logic ovf, input logic unf);
        chk({tag, " sp"},    32'(bus.SP_OUT), 32'(sp));
        chk({tag, " count"}, 32'(bus.COUNT),  32'(cnt));
        chk({tag, " full"},  32'(bus.FULL),   32'(cnt == 9'd256));
        chk({tag, " empty"}, 32'(bus.EMPTY),  32'(cnt == 9'd0));
        chk({tag, " ovf"},   32'(bus.OVF),    32'(ovf));
        chk({tag, " unf"},   32'(bus.UNF),    32'(unf));
    endtask

    // Drive one cycle, check read data before the edge and state after it
    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        bus.PUSH = t.push; bus.POP = t.pop; bus.SCR_WE = t.we; bus.SP_LD = t.ld;
        bus.ERR_CLR = t.clr; bus.SCR_ADDR = t.addr; bus.SCR_DIN = t.din;
        bus.SP_DIN = t.spd;
        #1;
        if (t.cd) chk({tag, " dout"}, 32'(bus.DATA_OUT), 32'(t.dout));
        @(posedge clk);
        #1;
        chk_regs(tag, t.sp, t.cnt, t.ovf, t.unf);
        idle();
    endtask

    task automatic read_chk(input logic [7:0] addr, input logic [9:0] exp, input string tag);
        @(negedge clk);
        idle();
        bus.SCR_ADDR = addr;
        #1;
        chk(tag, 32'(bus.DATA_OUT), 32'(exp));
    endtask

    vec_t tbl [23];

    initial begin
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_regs("reset", 8'h00, 9'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //          push pop we ld clr addr   din     spd   cd dout    sp     cnt  ovf unf
        tbl[0]  = v(1, 0, 0, 0, 0, 8'h00, 10'h155, 8'h00, 0, 10'h000, 8'hFF, 9'd1, 0, 0);
        tbl[1]  = v(1, 0, 0, 0, 0, 8'h00, 10'h2AA, 8'h00, 0, 10'h000, 8'hFE, 9'd2, 0, 0);
        tbl[2]  = v(0, 1, 0, 0, 0, 8'h00, 10'h000, 8'h00, 1, 10'h2AA, 8'hFF, 9'd1, 0, 0);
        tbl[3]  = v(0, 1, 0, 0, 0, 8'h00, 10'h000, 8'h00, 1, 10'h155, 8'h00, 9'd0, 0, 0);
        tbl[4]  = v(0, 1, 0, 0, 0, 8'h00, 10'h000, 8'h00, 0, 10'h000, 8'h00, 9'd0, 0, 1);
        tbl[5]  = v(0, 0, 0, 0, 1, 8'h00, 10'h000, 8'h00, 0, 10'h000, 8'h00, 9'd0, 0, 0);
        tbl[6]  = v(0, 0, 1, 0, 0, 8'h10, 10'h3FF, 8'h00, 0, 10'h000, 8'h00, 9'd0, 0, 0);
        tbl[7]  = v(0, 0, 0, 0, 0, 8'h10, 10'h000, 8'h00, 1, 10'h3FF, 8'h00, 9'd0, 0, 0);
        tbl[8]  = v(0, 0, 1, 0, 0, 8'h20, 10'h000, 8'h00, 0, 10'h000, 8'h00, 9'd0, 0, 0);
        tbl[9]  = v(1, 0, 1, 0, 0, 8'h20, 10'h0AB, 8'h00, 0, 10'h000, 8'hFF, 9'd1, 0, 0);
        tbl[10] = v(0, 0, 0, 0, 0, 8'h20, 10'h000, 8'h00, 1, 10'h000, 8'hFF, 9'd1, 0, 0);
        tbl[11] = v(0, 0, 0, 0, 0, 8'hFF, 10'h000, 8'h00, 1, 10'h0AB, 8'hFF, 9'd1, 0, 0);
        tbl[12] = v(1, 0, 0, 0, 0, 8'h00, 10'h0CD, 8'h00, 0, 10'h000, 8'hFE, 9'd2, 0, 0);
        tbl[13] = v(1, 0, 0, 0, 0, 8'h00, 10'h0EF, 8'h00, 0, 10'h000, 8'hFD, 9'd3, 0, 0);
        tbl[14] = v(1, 0, 1, 1, 0, 8'h10, 10'h000, 8'h80, 0, 10'h000, 8'h80, 9'd0, 0, 0);
        tbl[15] = v(1, 0, 0, 0, 0, 8'h00, 10'h001, 8'h00, 0, 10'h000, 8'h7F, 9'd1, 0, 0);
        tbl[16] = v(1, 1, 0, 0, 0, 8'h00, 10'h002, 8'h00, 1, 10'h001, 8'h7F, 9'd1, 0, 0);
        tbl[17] = v(0, 0, 0, 0, 0, 8'h7F, 10'h000, 8'h00, 1, 10'h002, 8'h7F, 9'd1, 0, 0);
        tbl[18] = v(0, 0, 0, 0, 0, 8'h10, 10'h000, 8'h00, 1, 10'h3FF, 8'h7F, 9'd1, 0, 0);
        tbl[19] = v(0, 1, 0, 0, 0, 8'h00, 10'h000, 8'h00, 1, 10'h002, 8'h80, 9'd0, 0, 0);
        tbl[20] = v(1, 1, 0, 0, 0, 8'h00, 10'h3AA, 8'h00, 0, 10'h000, 8'h80, 9'd0, 0, 1);
        tbl[21] = v(0, 1, 0, 0, 1, 8'h00, 10'h000, 8'h00, 0, 10'h000, 8'h80, 9'd0, 0, 1);
        tbl[22] = v(0, 0, 0, 0, 1, 8'h00, 10'h000, 8'h00, 0, 10'h000, 8'h80, 9'd0, 0, 0);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Fill the whole stack from SP=0, then overflow it
        apply(v(0, 0, 0, 1, 0, 8'h00, 10'h000, 8'h00, 0, 10'h000, 8'h00, 9'd0, 0, 0), "fill_ld");
        for (int i = 0; i < 256; i++) begin
            apply(v(1, 0, 0, 0, 0, 8'h00, 10'(i), 8'h00, 0, 10'h000,
                    8'(255 - i), 9'(i + 1), 0, 0), $sformatf("fill%0d", i));
        end
        apply(v(1, 0, 0, 0, 0, 8'h00, 10'h3FF, 8'h00, 0, 10'h000, 8'h00, 9'd256, 1, 0), "ovf_push");
        for (int i = 0; i < 256; i++) begin
            read_chk(8'(255 - i), 10'(i), $sformatf("ram%0d", 255 - i));
        end
        apply(v(1, 0, 0, 0, 1, 8'h00, 10'h3FF, 8'h00, 0, 10'h000, 8'h00, 9'd256, 1, 0), "clr_vs_ovf");
        apply(v(0, 0, 0, 0, 1, 8'h00, 10'h000, 8'h00, 0, 10'h000, 8'h00, 9'd256, 0, 0), "ovf_clr");
        apply(v(1, 0, 0, 0, 0, 8'h00, 10'h3FF, 8'h00, 0, 10'h000, 8'h00, 9'd256, 1, 0), "ovf_again");
        apply(v(0, 1, 0, 0, 0, 8'h00, 10'h000, 8'h00, 1, 10'h0FF, 8'h01, 9'd255, 1, 0), "pop_full");

        // Reset asserted between edges while a push is pending
        @(negedge clk);
        bus.PUSH = 1'b1;
        bus.SCR_DIN = 10'h077;
        #2 rst_n = 1'b0;
        #1 chk_regs("mid_reset", 8'h00, 9'd0, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        apply(v(1, 0, 0, 0, 0, 8'h00, 10'h011, 8'h00, 0, 10'h000, 8'hFF, 9'd1, 0, 0), "post_reset");
        read_chk(8'hFF, 10'h011, "post_reset_ram");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
